// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
// Holds funct3 size codes, the access FSM state type and store lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } lsu_state_e;

    function automatic logic valid_load(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic valid_store(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    // Size is carried by funct3[1:0]; halves need off[0]=0, words need off=0.
    function automatic logic misaligned_access(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3)
            F3_B:    m = 4'b0001 << off;
            F3_H:    m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            F3_B:    w = {4{d[7:0]}};
            F3_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core/memory bus bundle for load_store_unit.
// Carries the misaligned flag only when LSU_MISALIGN_TRAP_EN is defined.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              start;
    logic              isLoad;
    logic              isStore;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] address;
    logic [31:0]       storeData;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic [3:0]        memWmask;
    logic              memRstrb;
    logic              memReady;
    logic [31:0]       memRdata;
    logic [31:0]       loadData;
    logic              busy;
    logic              done;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              misaligned;
`endif

    modport slave (
        input  start, isLoad, isStore, funct3, address, storeData, memReady, memRdata,
        output memAddr, memWdata, memWmask, memRstrb, loadData, busy, done
`ifdef LSU_MISALIGN_TRAP_EN
        , output misaligned
`endif
    );

    modport master (
        output start, isLoad, isStore, funct3, address, storeData, memReady, memRdata,
        input  memAddr, memWdata, memWmask, memRstrb, loadData, busy, done
`ifdef LSU_MISALIGN_TRAP_EN
        , input misaligned
`endif
    );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load lane selection and sign/zero extension of the read word.
// Reserved funct3 codes yield zero.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (off)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];

        data = '0;
        case (funct3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data = {24'd0, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data = {16'd0, lane_h};
            F3_W:    data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one word-aligned access per start, extended load result.
// Optional LSU_MISALIGN_TRAP_EN short-circuits misaligned requests and flags them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    load_store_unit_if.slave bus
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic              mem_rstrb_q, mem_rstrb_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              done_q, done_d;
    logic              op_load_q, op_load_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              misaligned_q, misaligned_d;
`endif

    logic [31:0] aligned_data;
    logic        req_access;
    logic        req_valid;

    load_align u_align (
        .rdata  (bus.memRdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (aligned_data)
    );

    // isLoad wins when both request bits are set.
    assign req_access = bus.isLoad || bus.isStore;
    assign req_valid  = bus.isLoad ? valid_load(bus.funct3) : valid_store(bus.funct3);

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = '0;
        mem_rstrb_d = 1'b0;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        op_load_d   = op_load_q;
        f3_d        = f3_q;
        off_d       = off_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mem_addr_d  = {bus.address[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = store_wdata(bus.funct3, bus.storeData);
                    op_load_d   = bus.isLoad;
                    f3_d        = bus.funct3;
                    off_d       = bus.address[1:0];
                    if (!req_access) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (!req_valid) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        load_data_d = '0;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (misaligned_access(bus.funct3, bus.address[1:0])) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        misaligned_d = 1'b1;
                    end
`endif
                    else begin
                        state_d = ISSUE;
                        if (bus.isLoad) begin
                            mem_rstrb_d = 1'b1;
                        end else begin
                            mem_wmask_d = store_mask(bus.funct3, bus.address[1:0]);
                        end
                    end
                end
            end
            ISSUE, WAIT: begin
                if (bus.memReady) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (op_load_q) begin
                        load_data_d = aligned_data;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            mem_rstrb_q <= 1'b0;
            load_data_q <= '0;
            done_q      <= 1'b0;
            op_load_q   <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            mem_rstrb_q <= mem_rstrb_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            op_load_q   <= op_load_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    assign bus.memAddr  = mem_addr_q;
    assign bus.memWdata = mem_wdata_q;
    assign bus.memWmask = mem_wmask_q;
    assign bus.memRstrb = mem_rstrb_q;
    assign bus.loadData = load_data_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != IDLE);
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, corner sequences, random vs model.
module tb_load_store_unit;

    logic CLK;
    logic RESET;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int unsigned delay;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic        e_rstrb;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
        int unsigned e_done;
        logic        e_mis;
    } txn_t;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_load;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: expected bus behaviour from the access rules, using plain arithmetic.
    function automatic txn_t model(input txn_t t, input logic [31:0] prev);
        txn_t        r;
        int unsigned off;
        bit          access, valid, mis, trap, normal;
        logic [31:0] v;
        r      = t;
        off    = 32'(t.addr[1:0]);
        access = t.ld || t.st;
        valid  = t.ld ? (t.f3 == 0 || t.f3 == 1 || t.f3 == 2 || t.f3 == 4 || t.f3 == 5)
                      : (t.f3 <= 2);
        mis    = ((t.f3 % 4 == 1) && (off % 2 == 1)) || ((t.f3 % 4 == 2) && (off != 0));
`ifdef LSU_MISALIGN_TRAP_EN
        trap = access && valid && mis;
`else
        trap = 1'b0;
`endif
        normal    = access && valid && !trap;
        r.e_addr  = t.addr & 32'hFFFF_FFFC;
        r.e_done  = normal ? 2 + t.delay : 1;
        r.e_rstrb = normal && t.ld;
        r.e_mask  = 4'd0;
        if (normal && !t.ld) begin
            if (t.f3 == 0)      r.e_mask = 4'((1 << off) & 15);
            else if (t.f3 == 1) r.e_mask = 4'((3 << ((off / 2) * 2)) & 15);
            else                r.e_mask = 4'd15;
        end
        if (t.f3 == 0)      r.e_wdata = {24'd0, t.sdata[7:0]} * 32'h0101_0101;
        else if (t.f3 == 1) r.e_wdata = {16'd0, t.sdata[15:0]} * 32'h0001_0001;
        else                r.e_wdata = t.sdata;
        r.e_mis = trap;
        if (!access || trap)  r.e_load = prev;
        else if (!valid)      r.e_load = 32'd0;
        else if (!t.ld)       r.e_load = prev;
        else begin
            if (t.f3 % 4 == 0) begin
                v = (t.rdata >> (8 * off)) & 32'hFF;
                if (t.f3 < 4 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (t.f3 % 4 == 1) begin
                v = (t.rdata >> (16 * (off / 2))) & 32'hFFFF;
                if (t.f3 < 4 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = t.rdata;
            end
            r.e_load = v;
        end
        return r;
    endfunction

    task automatic run_txn(input txn_t t, input string tag);
        int unsigned strobes;
        int unsigned done_at;
        bit          seen;
        bus.isLoad    = t.ld;
        bus.isStore   = t.st;
        bus.funct3    = t.f3;
        bus.address   = t.addr;
        bus.storeData = t.sdata;
        bus.memRdata  = t.rdata;
        bus.memReady  = 1'b0;
        bus.start     = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        strobes = 0;
        done_at = 0;
        seen    = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (k == 1) check({tag, " busy"}, 32'(bus.busy), 32'd1);
            if (bus.memRstrb || bus.memWmask != 4'd0) begin
                strobes++;
                check({tag, " mask"}, 32'(bus.memWmask), 32'(t.e_mask));
                check({tag, " rstrb"}, 32'(bus.memRstrb), 32'(t.e_rstrb));
                check({tag, " addr@issue"}, bus.memAddr, t.e_addr);
                if (t.e_mask != 4'd0) check({tag, " wdata"}, bus.memWdata, t.e_wdata);
            end
            if (bus.done) begin
                seen    = 1'b1;
                done_at = k;
                check({tag, " loadData"}, bus.loadData, t.e_load);
                check({tag, " addr@done"}, bus.memAddr, t.e_addr);
`ifdef LSU_MISALIGN_TRAP_EN
                check({tag, " misaligned"}, 32'(bus.misaligned), 32'(t.e_mis));
`endif
            end else begin
                bus.memReady = (k == int'(1 + t.delay));
                @(negedge CLK);
            end
        end
        bus.memReady = 1'b0;
        check({tag, " done latency"}, 32'(done_at), 32'(t.e_done));
        check({tag, " strobe cycles"}, 32'(strobes),
              (t.e_mask != 4'd0 || t.e_rstrb) ? 32'd1 : 32'd0);
        @(negedge CLK);
        check({tag, " idle busy"}, 32'(bus.busy), 32'd0);
        check({tag, " done pulse"}, 32'(bus.done), 32'd0);
    endtask

    txn_t        tbl[12];
    txn_t        t;
    logic [31:0] after8;
    int unsigned cnt;

    initial begin
        RESET         = 1'b1;
        bus.start     = 1'b0;
        bus.isLoad    = 1'b0;
        bus.isStore   = 1'b0;
        bus.funct3    = 3'd0;
        bus.address   = 32'd0;
        bus.storeData = 32'd0;
        bus.memReady  = 1'b0;
        bus.memRdata  = 32'd0;

`ifdef LSU_MISALIGN_TRAP_EN
        after8 = 32'h0000_0000;
        tbl[8] = '{1, 0, 3'b010, 32'h101, 0, 32'h1234_5678, 0,
                   32'h100, 4'h0, 0, 32'h0, after8, 1, 1};
`else
        after8 = 32'h1234_5678;
        tbl[8] = '{1, 0, 3'b010, 32'h101, 0, 32'h1234_5678, 0,
                   32'h100, 4'h0, 1, 32'h0, after8, 2, 0};
`endif
        //           ld st f3      addr      sdata          rdata          dly e_addr   mask  rs  wdata          load           done mis
        tbl[0]  = '{0, 1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0,         0, 32'h100, 4'h8, 0, 32'hA5A5_A5A5, 32'h0,         2, 0};
        tbl[1]  = '{1, 0, 3'b000, 32'h102, 32'h0,         32'h0080_0000, 0, 32'h100, 4'h0, 1, 32'h0,         32'hFFFF_FF80, 2, 0};
        tbl[2]  = '{1, 0, 3'b100, 32'h102, 32'h0,         32'h0080_0000, 0, 32'h100, 4'h0, 1, 32'h0,         32'h0000_0080, 2, 0};
        tbl[3]  = '{1, 0, 3'b001, 32'h202, 32'h0,         32'hBEEF_1234, 3, 32'h200, 4'h0, 1, 32'h0,         32'hFFFF_BEEF, 5, 0};
        tbl[4]  = '{0, 1, 3'b001, 32'h006, 32'h1234_ABCD, 32'h0,         0, 32'h004, 4'hC, 0, 32'hABCD_ABCD, 32'hFFFF_BEEF, 2, 0};
        tbl[5]  = '{0, 1, 3'b010, 32'h00C, 32'hDEAD_BEEF, 32'h0,         1, 32'h00C, 4'hF, 0, 32'hDEAD_BEEF, 32'hFFFF_BEEF, 3, 0};
        tbl[6]  = '{1, 0, 3'b101, 32'h002, 32'h0,         32'h8001_7FFF, 0, 32'h000, 4'h0, 1, 32'h0,         32'h0000_8001, 2, 0};
        tbl[7]  = '{1, 0, 3'b011, 32'h010, 32'h0,         32'hFFFF_FFFF, 0, 32'h010, 4'h0, 0, 32'h0,         32'h0,         1, 0};
        tbl[9]  = '{0, 0, 3'b000, 32'h044, 32'h0,         32'h0,         0, 32'h044, 4'h0, 0, 32'h0,         after8,        1, 0};
        tbl[10] = '{1, 1, 3'b000, 32'h001, 32'h0,         32'h0000_FF00, 0, 32'h000, 4'h0, 1, 32'h0,         32'hFFFF_FFFF, 2, 0};
        tbl[11] = '{0, 1, 3'b100, 32'h020, 32'h0,         32'h0,         0, 32'h020, 4'h0, 0, 32'h0,         32'h0,         1, 0};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset memAddr", bus.memAddr, 32'd0);
        check("reset memWdata", bus.memWdata, 32'd0);
        check("reset memWmask", 32'(bus.memWmask), 32'd0);
        check("reset memRstrb", 32'(bus.memRstrb), 32'd0);
        check("reset loadData", bus.loadData, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i], $sformatf("tbl%0d", i));
        end

        // Second start while a store waits on memory must be dropped.
        bus.isLoad = 1'b0; bus.isStore = 1'b1; bus.funct3 = 3'b010;
        bus.address = 32'h40; bus.storeData = 32'h1122_3344; bus.memReady = 1'b0;
        bus.start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        check("seqA issue mask", 32'(bus.memWmask), 32'hF);
        @(negedge CLK);
        check("seqA wait busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b1; bus.isLoad = 1'b1; bus.isStore = 1'b0; bus.address = 32'h80;
        @(negedge CLK);
        bus.start = 1'b0;
        check("seqA addr held", bus.memAddr, 32'h40);
        check("seqA wdata held", bus.memWdata, 32'h1122_3344);
        check("seqA no rstrb", 32'(bus.memRstrb), 32'd0);
        bus.memReady = 1'b1;
        @(negedge CLK);
        bus.memReady = 1'b0;
        check("seqA done", 32'(bus.done), 32'd1);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (bus.memRstrb || bus.memWmask != 4'd0 || bus.done || bus.busy) cnt++;
        end
        check("seqA second start ignored", 32'(cnt), 32'd0);

        // Reset while waiting: no done, strobes low, late memReady ignored.
        bus.isLoad = 1'b1; bus.isStore = 1'b0; bus.funct3 = 3'b010;
        bus.address = 32'h300; bus.memRdata = 32'hCAFE_F00D;
        bus.start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        check("seqB issue rstrb", 32'(bus.memRstrb), 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("seqB busy after reset", 32'(bus.busy), 32'd0);
        check("seqB rstrb after reset", 32'(bus.memRstrb), 32'd0);
        check("seqB mask after reset", 32'(bus.memWmask), 32'd0);
        check("seqB done after reset", 32'(bus.done), 32'd0);
        bus.memReady = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (bus.done || bus.busy || bus.memRstrb) cnt++;
        end
        bus.memReady = 1'b0;
        check("seqB late memReady ignored", 32'(cnt), 32'd0);
        check("seqB loadData cleared", bus.loadData, 32'd0);
        model_load = 32'd0;

        for (int i = 0; i < 300; i++) begin
            int unsigned kind;
            kind    = $urandom_range(0, 9);
            t.ld    = (kind == 1) || (kind >= 2 && kind <= 5);
            t.st    = (kind == 1) || (kind >= 6);
            t.f3    = 3'($urandom_range(0, 7));
            t.addr  = $urandom;
            t.sdata = $urandom;
            t.rdata = $urandom;
            t.delay = $urandom_range(0, 3);
            t = model(t, model_load);
            run_txn(t, $sformatf("rnd%0d", i));
            model_load = t.e_load;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
